expr_vector_sequencer: RTL and testbench

- Self-test sequencer for the 12-operand combinational expression blocks (a0..a5, b0..b5 → 90-bit y).
- Drives pseudo-random operand vectors from a 64-bit LFSR, waits a programmable settle time, then captures y.
- Folds each capture into a 32-bit MISR signature.
- Sits between the regression harness (start/done handshake) and one expression instance.

---
 rtl/expr_vector_sequencer.sv | 136 +++++++++++++
 tb/tb_expr_vector_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_vector_sequencer.sv
// Self-test sequencer: applies LFSR-generated operand vectors to one expression
// block, waits a programmable settle time, and folds each y capture into a MISR.
module expr_vector_sequencer #(
  parameter int OP_W  = 60,
  parameter int Y_W   = 90,
  parameter int CNT_W = 16,
  parameter int SET_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic [31:0]      seed,
  input  logic [SET_W-1:0] settle_cycles,
  output logic [OP_W-1:0]  operands,
  input  logic [Y_W-1:0]   y_in,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [31:0]      signature,
  output logic [CNT_W-1:0] vec_count
);
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_e;

  typedef struct packed {
    logic [CNT_W-1:0] n;
    logic [SET_W-1:0] s;
  } run_cfg_t;

  state_e           state_q;
  run_cfg_t         cfg_q;
  logic [63:0]      lfsr_q;
  logic [SET_W-1:0] cnt_q;
  logic [OP_W-1:0]  ops_q;
  logic [31:0]      sig_q;
  logic [CNT_W-1:0] vcnt_q;
  logic             busy_q, done_q, aborted_q;

  logic [63:0]      lfsr_init_d, lfsr_step_d;
  logic [31:0]      fold_d, sig_d;
  logic [CNT_W-1:0] vcnt_d;
  logic             last_vec_d;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign lfsr_init_d = (seed == 32'h0) ? 64'h1 : {seed, seed};
  assign lfsr_step_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 64'h0);

  // 90-bit result compressed to 32 bits before entering the CRC-32 style MISR.
  assign fold_d     = y_in[31:0] ^ y_in[63:32] ^ 32'(y_in[Y_W-1:64]);
  assign sig_d      = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold_d;
  assign vcnt_d     = vcnt_q + 1'b1;
  assign last_vec_d = (vcnt_d == cfg_q.n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      lfsr_q    <= '0;
      cnt_q     <= '0;
      ops_q     <= '0;
      sig_q     <= 32'hFFFF_FFFF;
      vcnt_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cfg_q.n <= num_vectors;
            cfg_q.s <= settle_cycles;
            lfsr_q  <= lfsr_init_d;
            sig_q   <= 32'hFFFF_FFFF;
            vcnt_q  <= '0;
            if (num_vectors == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              ops_q   <= lfsr_init_d[OP_W-1:0];
              cnt_q   <= settle_cycles;
              state_q <= SETTLE;
              busy_q  <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (cnt_q == '0) begin
            state_q <= CAPTURE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else begin
            sig_q  <= sig_d;
            vcnt_q <= vcnt_d;
            if (last_vec_d) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              lfsr_q  <= lfsr_step_d;
              ops_q   <= lfsr_step_d[OP_W-1:0];
              cnt_q   <= cfg_q.s;
              state_q <= SETTLE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign operands  = ops_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign signature = sig_q;
  assign vec_count = vcnt_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Bench for expr_vector_sequencer: run-level reference model checked every cycle,
// directed runs pinning literal timing/signature values, then random traffic.
module tb_expr_vector_sequencer;
  localparam int OP_W = 60, Y_W = 90, CNT_W = 16, SET_W = 4;

  logic             clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [31:0]      seed = '0;
  logic [SET_W-1:0] settle_cycles = '0;
  logic [Y_W-1:0]   y_in = '0;
  logic [OP_W-1:0]  operands;
  logic             busy, done, aborted;
  logic [31:0]      signature;
  logic [CNT_W-1:0] vec_count;

  int checks = 0, errors = 0;
  int y_mode = 0;

  always #5 clk = ~clk;

  expr_vector_sequencer #(.OP_W(OP_W), .Y_W(Y_W), .CNT_W(CNT_W), .SET_W(SET_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .num_vectors(num_vectors), .seed(seed), .settle_cycles(settle_cycles),
    .operands(operands), .y_in(y_in), .busy(busy), .done(done), .aborted(aborted),
    .signature(signature), .vec_count(vec_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (y_mode)
      1:       y_in = '0;
      2:       y_in = '1;
      default: y_in = Y_W'({$urandom, $urandom, $urandom});
    endcase
  end

  // ---------------- reference model (run-level arithmetic) ----------------
  function automatic logic [63:0] m_step(input logic [63:0] s);
    logic b;
    b = s[0];
    s = s >> 1;
    if (b) s = s ^ 64'hD800_0000_0000_0000;
    return s;
  endfunction

  function automatic logic [31:0] m_fold(input logic [31:0] sig, input logic [Y_W-1:0] y);
    logic [31:0] f, r;
    f = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
    r = {sig[30:0], 1'b0};
    if (sig[31]) r = r ^ 32'h04C11DB7;
    return r ^ f;
  endfunction

  bit               m_run = 0;
  int               m_rel = 0, m_n = 0, m_s = 0;
  logic [63:0]      m_lfsr = '0;
  logic             e_busy = 0, e_done = 0, e_ab = 0;
  logic [OP_W-1:0]  e_ops = '0;
  logic [31:0]      e_sig = 32'hFFFF_FFFF;
  logic [CNT_W-1:0] e_vc = '0;

  // m_rel counts cycles since the accepted start; vector k is captured when
  // m_rel == k*(S+2), and its operands are visible from (k-1)*(S+2)+1.
  always @(posedge clk or negedge rst_n) begin : mdl
    logic was_done;
    if (!rst_n) begin
      m_run = 0; e_busy = 0; e_done = 0; e_ab = 0;
      e_ops = '0; e_sig = 32'hFFFF_FFFF; e_vc = '0; m_lfsr = '0;
    end else begin
      was_done = e_done;
      e_done = 0;
      e_ab = 0;
      if (m_run) begin
        if (abort) begin
          m_run = 0; e_ab = 1; e_busy = 0;
        end else if (m_rel % (m_s + 2) == 0) begin
          e_sig = m_fold(e_sig, y_in);
          e_vc  = CNT_W'(m_rel / (m_s + 2));
          if (int'(e_vc) == m_n) begin
            m_run = 0; e_done = 1; e_busy = 0;
          end else begin
            m_lfsr = m_step(m_lfsr);
            e_ops  = m_lfsr[OP_W-1:0];
          end
        end
        m_rel++;
      end else if (start && !was_done) begin
        m_n    = int'(num_vectors);
        m_s    = int'(settle_cycles);
        m_lfsr = (seed == 0) ? 64'h1 : {seed, seed};
        e_sig  = 32'hFFFF_FFFF;
        e_vc   = '0;
        if (m_n == 0) e_done = 1;
        else begin
          m_run = 1; m_rel = 1; e_busy = 1; e_ops = m_lfsr[OP_W-1:0];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("aborted", 64'(aborted), 64'(e_ab));
      chk("operands", 64'(operands), 64'(e_ops));
      chk("signature", 64'(signature), 64'(e_sig));
      chk("vec_count", 64'(vec_count), 64'(e_vc));
    end
  end

  // ---------------- directed run observation ----------------
  logic [OP_W-1:0]  o_ops [64];
  logic [31:0]      o_sig [64];
  logic [CNT_W-1:0] o_vc  [64];
  logic             o_busy[64], o_done[64], o_ab[64];

  // Called at posedge+1 with the DUT idle; cycle r=0 is the start cycle.
  task automatic run_obs(input int n, input int s, input logic [31:0] sd,
                         input int start_rel, input int abort_rel, input int maxc);
    for (int i = 0; i < 64; i++) begin
      o_ops[i] = '0; o_sig[i] = '0; o_vc[i] = '0;
      o_busy[i] = 0; o_done[i] = 0; o_ab[i] = 0;
    end
    num_vectors = CNT_W'(n); settle_cycles = SET_W'(s); seed = sd;
    for (int r = 0; r <= maxc; r++) begin
      start = (r == 0) || (r == start_rel);
      abort = (r == abort_rel);
      @(negedge clk);
      if (r < 64) begin
        o_ops[r] = operands; o_sig[r] = signature; o_vc[r] = vec_count;
        o_busy[r] = busy; o_done[r] = done; o_ab[r] = aborted;
      end
      @(posedge clk); #1;
    end
    start = 0; abort = 0;
  endtask

  task automatic scan(output int fb, output int lb, output int nb, output int fd, output int fa);
    fb = -1; lb = -1; nb = 0; fd = -1; fa = -1;
    for (int i = 0; i < 64; i++) begin
      if (o_busy[i]) begin if (fb < 0) fb = i; lb = i; nb++; end
      if (o_done[i] && fd < 0) fd = i;
      if (o_ab[i] && fa < 0) fa = i;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    int fb, lb, nb, fd, fa;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'h0);
    chk("rst done", 64'(done), 64'h0);
    chk("rst signature", 64'(signature), 64'hFFFF_FFFF);
    chk("rst operands", 64'(operands), 64'h0);
    chk("rst vec_count", 64'(vec_count), 64'h0);
    @(negedge clk); #2 rst_n = 1;
    idle(2);

    // N=0: immediate done, nothing else moves
    y_mode = 0;
    run_obs(0, 3, $urandom, -1, -1, 4);
    scan(fb, lb, nb, fd, fa);
    chk("n0 done cycle", 64'(fd), 64'd1);
    chk("n0 busy count", 64'(nb), 64'd0);
    chk("n0 signature", 64'(o_sig[2]), 64'hFFFF_FFFF);
    chk("n0 vec_count", 64'(o_vc[2]), 64'd0);
    idle(2);

    // seed=0, N=1, S=0, y=0
    y_mode = 1;
    run_obs(1, 0, 32'h0, -1, -1, 5);
    scan(fb, lb, nb, fd, fa);
    chk("t2 operands", 64'(o_ops[1]), 64'h1);
    chk("t2 done cycle", 64'(fd), 64'd3);
    chk("t2 signature", 64'(o_sig[3]), 64'hFB3E_E249);
    chk("t2 vec_count", 64'(o_vc[3]), 64'd1);
    idle(2);

    // seed=0, N=2, S=0, y all ones
    y_mode = 2;
    run_obs(2, 0, 32'h0, -1, -1, 7);
    scan(fb, lb, nb, fd, fa);
    chk("t3 operands0", 64'(o_ops[1]), 64'h1);
    chk("t3 operands1", 64'(o_ops[3]), 64'h800_0000_0000_0000);
    chk("t3 first fold", 64'(o_sig[3]), 64'hF8C1_1DB6);
    chk("t3 done cycle", 64'(fd), 64'd5);
    idle(2);

    // seed=0, N=2, S=3: captures at 5 and 10
    y_mode = 0;
    run_obs(2, 3, 32'h0, -1, -1, 13);
    scan(fb, lb, nb, fd, fa);
    chk("t4 busy first", 64'(fb), 64'd1);
    chk("t4 busy last", 64'(lb), 64'd10);
    chk("t4 done cycle", 64'(fd), 64'd11);
    chk("t4 vc before cap1", 64'(o_vc[5]), 64'd0);
    chk("t4 vc after cap1", 64'(o_vc[6]), 64'd1);
    chk("t4 vc final", 64'(o_vc[11]), 64'd2);
    idle(2);

    // N=5, S=2, abort at cycle 6
    run_obs(5, 2, $urandom, -1, 6, 30);
    scan(fb, lb, nb, fd, fa);
    chk("t5 aborted cycle", 64'(fa), 64'd7);
    chk("t5 no done", 64'(fd), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t5 vec_count", 64'(o_vc[8]), 64'd1);
    chk("t5 busy last", 64'(lb), 64'd6);
    idle(2);

    // start during run ignored, then restart reinitialises signature
    run_obs(3, 1, $urandom, 2, -1, 12);
    scan(fb, lb, nb, fd, fa);
    chk("t6 done cycle", 64'(fd), 64'd10);
    chk("t6 vec_count", 64'(o_vc[11]), 64'd3);
    run_obs(1, 0, $urandom, 3, -1, 8);
    scan(fb, lb, nb, fd, fa);
    chk("t6 sig reinit", 64'(o_sig[1]), 64'hFFFF_FFFF);
    chk("t6 vc reinit", 64'(o_vc[1]), 64'd0);
    chk("t6 start in done ignored", 64'(nb), 64'd2);
    chk("t6b done cycle", 64'(fd), 64'd3);
    idle(2);

    // reset asserted mid-run
    run_obs(5, 2, $urandom, -1, -1, 5);
    #2 rst_n = 0;
    #1;
    chk("mrst busy", 64'(busy), 64'h0);
    chk("mrst signature", 64'(signature), 64'hFFFF_FFFF);
    chk("mrst vec_count", 64'(vec_count), 64'h0);
    chk("mrst operands", 64'(operands), 64'h0);
    @(negedge clk); #2 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mrst no done", 64'(done), 64'h0);
      chk("mrst no aborted", 64'(aborted), 64'h0);
    end
    idle(1);

    // random traffic checked by the model
    y_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 8 == 0) begin
        num_vectors   = CNT_W'($urandom_range(0, 7));
        settle_cycles = SET_W'($urandom_range(0, 15));
        seed          = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      end
      start = ($urandom % 6 == 0);
      abort = ($urandom % 48 == 0);
      @(posedge clk); #1;
    end
    start = 0; abort = 0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
